serial_adder: RTL and testbench
===============================

# serial_adder

Parametrised bit-serial adder/subtractor, the sequential successor to the combinational half adder. It accepts two WIDTH-bit operands on a start pulse and computes one result bit per clock through a single full-adder cell built from two half-adder stages. It reports sum, carry-out and signed overflow with a busy/done handshake. It is a small-area arithmetic unit for control paths where latency is cheap and gates are not.

## Interface
- WIDTH, 8, operand and result width in bits; legal range 2..32.
- clk  in  1  rising-edge clock, sole clock domain.
- rst_n  in  1  reset, asynchronous assert, active-low; clears all state and outputs.
- start  in  1  request; sampled on rising clk edge; accepted only when the FSM is in IDLE or DONE.
- sub  in  1  mode; 0 = a + b + cin, 1 = a - b (cin ignored); latched on accept.
- a  in  WIDTH  operand A, latched on accept.
- b  in  WIDTH  operand B, latched on accept.
- cin  in  1  carry-in for add mode, latched on accept.
- busy  out  1  high while bits are being processed (SHIFT state).
- done  out  1  one-cycle pulse; results are valid and stable from this cycle onward.
- sum  out  WIDTH  registered result.
- cout  out  1  carry-out; in sub mode 1 = no borrow (a >= b unsigned).
- overflow  out  1  two's-complement overflow: carry into MSB XOR carry out of MSB.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE -> SHIFT on accepted start; SHIFT -> DONE after bit WIDTH-1; DONE -> SHIFT on accepted start, else DONE -> IDLE.
- On accept:
  - load A shift register with a.
  - load B shift register with b (sub=0) or ~b (sub=1).
  - carry register = cin (sub=0) or 1 (sub=1).
  - bit counter = 0.
- Each SHIFT cycle:
  - LSBs of A/B plus the carry register feed the full-adder cell.
  - Sum bit shifts into the MSB of the result shift register; A/B shift right.
  - Carry register updates.
  - Counter increments.
  - Carry into the MSB is captured when counter = WIDTH-1.
- On the final SHIFT cycle, the sum/cout/overflow output registers load the completed result.
- Outputs hold until the next operation completes; they do not change during SHIFT.
- start is ignored during SHIFT, including when held high continuously. It is not queued.
- Inputs a, b, sub, cin are don't-care except on the accepting edge.
- Arithmetic is modulo 2^WIDTH; no saturation.

## Timing
- Edge E0 accepts start. Edges E1..EWIDTH process bits 0..WIDTH-1.
- busy is high from after E0 until after EWIDTH: exactly WIDTH cycles.
- sum/cout/overflow update at EWIDTH. done is high for the one cycle after EWIDTH.
- Latency from start edge to done: WIDTH+1 cycles.
- Back-to-back start asserted during the done cycle is accepted. done still pulses that cycle, and busy rises on the next cycle. Peak throughput is one result per WIDTH+1 cycles.
- Reset values: busy=0, done=0, sum=0, cout=0, overflow=0, FSM=IDLE, counter=0.
- rst_n asserted mid-operation aborts immediately (asynchronous). The partial result is discarded and not output.
- After rst_n deasserts, the first edge may accept start.

## Test plan
- Reset abort: start add a=0x12 b=0x34 (WIDTH=8), assert rst_n low at E4 -> busy/done/sum/cout/overflow all 0 asynchronously. After release, no done pulse appears without a new start.
- Basic add, WIDTH=8: a=0x0F b=0x01 cin=0 sub=0 -> busy high 8 cycles, done at cycle 9, sum=0x10 cout=0 overflow=0.
- Carry chain and cin: a=0xFF b=0x01 cin=1 -> sum=0x01 cout=1 overflow=0. Separately a=0x7F b=0x01 cin=0 -> sum=0x80 cout=0 overflow=1.
- Subtract: a=0x05 b=0x07 sub=1 cin=1 -> sum=0xFE cout=0 overflow=0. a=0x80 b=0x01 sub=1 -> sum=0x7F cout=1 overflow=1.
- Handshake:
  - start held high continuously with changing operands -> only the operands sampled at IDLE/DONE edges are used.
  - Results arrive every 9 cycles; start pulses during busy produce no extra done.
- Parameter sweep: WIDTH=2 exhaustive (all a, b, cin, sub) and WIDTH=32 with 1000 random vectors -> every result matches the reference model (a±b+cin mod 2^WIDTH, cout, signed overflow). done arrives exactly WIDTH+1 cycles after accept.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell (two half-adder stages)
// walks the operands LSB first, one bit per clock, behind a busy/done handshake.

module half_adder (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);
    assign s = x ^ y;
    assign c = x & y;
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state, nxt;
    logic [WIDTH-1:0] areg, breg;
    logic [WIDTH-2:0] res;      // result bits gathered so far, newest at MSB
    logic [WIDTH-1:0] cat;      // result including the bit being produced now
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             accept, last;
    logic             s0, c0, s1, c1, co;

    // Full-adder cell from two half-adder stages
    half_adder u_ha0 (.x(areg[0]), .y(breg[0]), .s(s0), .c(c0));
    half_adder u_ha1 (.x(s0),      .y(carry),   .s(s1), .c(c1));
    assign co = c0 | c1;

    assign accept = start && (state != SHIFT);
    assign last   = (state == SHIFT) && (cnt == CW'(WIDTH - 1));
    assign cat    = {s1, res};

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end

    // Next-state and handshake outputs
    always_comb begin
        nxt  = state;
        busy = 1'b0;
        done = 1'b0;
        case (state)
            IDLE:  if (start) nxt = SHIFT;
            SHIFT: begin
                busy = 1'b1;
                if (last) nxt = DONE;
            end
            DONE: begin
                done = 1'b1;
                nxt  = start ? SHIFT : IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    // Operand shift registers, carry and bit counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            areg  <= '0;
            breg  <= '0;
            res   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
        end else if (accept) begin
            areg  <= a;
            // subtraction is a + ~b + 1
            breg  <= sub ? ~b : b;
            carry <= sub ? 1'b1 : cin;
            cnt   <= '0;
        end else if (state == SHIFT) begin
            areg  <= areg >> 1;
            breg  <= breg >> 1;
            res   <= cat[WIDTH-1:1];
            carry <= co;
            cnt   <= cnt + CW'(1);
        end
    end

    // Result registers load only on the final bit so they stay stable during SHIFT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else if (last) begin
            sum      <= cat;
            cout     <= co;
            // carry register holds the carry into the MSB on the last bit
            overflow <= carry ^ co;
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
// Directed and sweep checks of serial_adder at WIDTH 8, 2 and 32.

module tb_serial_adder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        st8 = 1'b0, st2 = 1'b0, st32 = 1'b0;
    logic        sub = 1'b0, cin = 1'b0;
    logic [31:0] a = '0, b = '0;

    logic        busy8, done8, cout8, ov8;
    logic [7:0]  sum8;
    logic        busy2, done2, cout2, ov2;
    logic [1:0]  sum2;
    logic        busy32, done32, cout32, ov32;
    logic [31:0] sum32;

    int nchk = 0, npass = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .start(st8), .sub(sub), .a(a[7:0]), .b(b[7:0]), .cin(cin),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .overflow(ov8));
    serial_adder #(.WIDTH(2)) u2 (
        .clk(clk), .rst_n(rst_n), .start(st2), .sub(sub), .a(a[1:0]), .b(b[1:0]), .cin(cin),
        .busy(busy2), .done(done2), .sum(sum2), .cout(cout2), .overflow(ov2));
    serial_adder #(.WIDTH(32)) u32 (
        .clk(clk), .rst_n(rst_n), .start(st32), .sub(sub), .a(a), .b(b), .cin(cin),
        .busy(busy32), .done(done32), .sum(sum32), .cout(cout32), .overflow(ov32));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        assert (obs === exp) npass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Reference: {overflow, cout, sum} of a +/- b at width w
    function automatic logic [33:0] model(input int w, input logic [31:0] av, input logic [31:0] bv,
                                          input logic ci, input logic sb);
        logic [63:0] mask, aa, bb, tot;
        logic [31:0] s;
        logic        c, o;
        mask = (64'd1 << w) - 64'd1;
        aa   = {32'd0, av} & mask;
        bb   = sb ? (~{32'd0, bv} & mask) : ({32'd0, bv} & mask);
        tot  = aa + bb + {63'd0, (sb ? 1'b1 : ci)};
        s    = tot[31:0] & mask[31:0];
        c    = tot[w];
        o    = (aa[w-1] == bb[w-1]) && (s[w-1] != aa[w-1]);
        return {o, c, s};
    endfunction

    function automatic logic busy_of(input int w);
        case (w)
            2:       return busy2;
            8:       return busy8;
            default: return busy32;
        endcase
    endfunction

    function automatic logic done_of(input int w);
        case (w)
            2:       return done2;
            8:       return done8;
            default: return done32;
        endcase
    endfunction

    task automatic set_start(input int w, input logic v);
        case (w)
            2:       st2 = v;
            8:       st8 = v;
            default: st32 = v;
        endcase
    endtask

    // One operation: lat counts cycles from accept to done (done cycle = WIDTH+1)
    task automatic run(input int w, input logic [31:0] av, input logic [31:0] bv,
                       input logic ci, input logic sb,
                       output logic [31:0] so, output logic co, output logic ov,
                       output int lat, output int bc);
        @(negedge clk);
        a = av; b = bv; cin = ci; sub = sb;
        set_start(w, 1'b1);
        @(negedge clk);
        set_start(w, 1'b0);
        a = $urandom; b = $urandom; cin = 1'($urandom); sub = 1'($urandom);
        lat = 0; bc = 0;
        while (lat < 100) begin
            lat++;
            if (busy_of(w)) bc++;
            if (done_of(w)) break;
            @(negedge clk);
        end
        case (w)
            2:       begin so = {30'd0, sum2}; co = cout2;  ov = ov2;  end
            8:       begin so = {24'd0, sum8}; co = cout8;  ov = ov8;  end
            default: begin so = sum32;         co = cout32; ov = ov32; end
        endcase
    endtask

    logic [31:0] so;
    logic        co, ov;
    int          lat, bc, nd;
    logic [33:0] m;

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_state", {busy8, done8, cout8, ov8, sum8}, 64'd0);
        rst_n = 1'b1;

        // basic add: {lat, busy cycles, cout, ov, sum}
        run(8, 32'h0F, 32'h01, 1'b0, 1'b0, so, co, ov, lat, bc);
        chk("add_0f_01", {lat[7:0], bc[7:0], co, ov, so}, {8'd9, 8'd8, 1'b0, 1'b0, 32'h10});
        run(8, 32'hFF, 32'h01, 1'b1, 1'b0, so, co, ov, lat, bc);
        chk("add_ff_01_cin", {co, ov, so}, {1'b1, 1'b0, 32'h01});
        run(8, 32'h7F, 32'h01, 1'b0, 1'b0, so, co, ov, lat, bc);
        chk("add_7f_01_ovf", {co, ov, so}, {1'b0, 1'b1, 32'h80});
        run(8, 32'h05, 32'h07, 1'b1, 1'b1, so, co, ov, lat, bc);
        chk("sub_05_07", {co, ov, so}, {1'b0, 1'b0, 32'hFE});
        run(8, 32'h80, 32'h01, 1'b0, 1'b1, so, co, ov, lat, bc);
        chk("sub_80_01", {lat[7:0], co, ov, so}, {8'd9, 1'b1, 1'b1, 32'h7F});

        // outputs must hold through SHIFT of the next operation
        @(negedge clk);
        a = 32'h12; b = 32'h34; sub = 1'b0; cin = 1'b0; st8 = 1'b1;
        @(negedge clk);
        st8 = 1'b0;
        repeat (3) @(negedge clk);
        chk("hold_during_shift", {busy8, done8, sum8}, {1'b1, 1'b0, 8'h7F});
        // reset mid-operation aborts asynchronously
        #2 rst_n = 1'b0;
        #1 chk("reset_abort", {busy8, done8, cout8, ov8, sum8}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        repeat (15) begin
            @(negedge clk);
            if (done8) nd++;
        end
        chk("no_done_after_abort", nd, 0);

        // start held high: only operands at IDLE/DONE edges are used
        @(negedge clk);
        a = 32'h01; b = 32'h02; sub = 1'b0; cin = 1'b0; st8 = 1'b1;
        nd = 0;
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk);
            if (done8) nd++;
            if (k == 9)  chk("hold_first", {done8, sum8}, {1'b1, 8'h03});
            if (k == 10) chk("hold_busy_again", {busy8, done8}, {1'b1, 1'b0});
            if (k == 18) chk("hold_second", {done8, sum8}, {1'b1, 8'h30});
            if (k == 9) begin
                a = 32'h10; b = 32'h20; sub = 1'b0; cin = 1'b0;
            end else begin
                a = 32'h40 + k; b = 32'h11; sub = k[0]; cin = 1'b1;
            end
            if (k == 18) st8 = 1'b0;
        end
        chk("hold_done_count", nd, 2);

        // start pulses while busy produce no extra done
        @(negedge clk);
        a = 32'h03; b = 32'h04; sub = 1'b0; cin = 1'b0; st8 = 1'b1;
        nd = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (done8) nd++;
            if (k == 9) chk("pulse_result", {done8, sum8}, {1'b1, 8'h07});
            st8 = (k >= 2 && k <= 7) ? k[0] : 1'b0;
            a = 32'hAA; b = 32'h55;
        end
        chk("pulse_done_count", {nd[7:0], sum8}, {8'd1, 8'h07});

        // WIDTH=2 exhaustive
        for (int s = 0; s < 2; s++)
            for (int ci = 0; ci < 2; ci++)
                for (int x = 0; x < 4; x++)
                    for (int y = 0; y < 4; y++) begin
                        run(2, x, y, ci[0], s[0], so, co, ov, lat, bc);
                        m = model(2, x, y, ci[0], s[0]);
                        chk($sformatf("w2 s%0d c%0d %0d,%0d", s, ci, x, y),
                            {lat[7:0], bc[7:0], ov, co, so}, {8'd3, 8'd2, m});
                    end

        // WIDTH=32 random
        for (int i = 0; i < 1000; i++) begin
            logic [31:0] x, y;
            logic        c, s;
            x = $urandom; y = $urandom; c = 1'($urandom); s = 1'($urandom);
            if (i == 0) begin x = 32'hFFFF_FFFF; y = 32'h1; c = 1'b1; s = 1'b0; end
            if (i == 1) begin x = 32'h8000_0000; y = 32'h1; s = 1'b1; end
            run(32, x, y, c, s, so, co, ov, lat, bc);
            m = model(32, x, y, c, s);
            chk($sformatf("w32 #%0d %h%s%h c%0d", i, x, s ? "-" : "+", y, c),
                {lat[7:0], bc[7:0], ov, co, so}, {8'd33, 8'd32, m});
        end

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule
